pipeline_sink_buffer: RTL and testbench
=======================================

// Module: pipeline_sink_buffer
// PURPOSE
//  Elastic buffer directly downstream of the address pipeline's last stage. Absorbs {address,id} words
//  from the pipeline, presents them in order to the final consumer and returns stall back up the pipeline.
//  Also keeps saturating occupancy/stall statistics for the security monitor.
//  The buffer is registered on both sides: the pipeline's stall input never sees a combinational path from the consumer.
// PARAMETERS
//  DEPTH        4   FIFO entries (power of two, >=2)
//  CNT_WIDTH    16  width of statistics counters
//  `ADDRESS_WIDTH, `ID_WIDTH from defines.vh (not redefined here)
// PORTS
//  clk            in   1               clock, all state on rising edge
//  reset          in   1               synchronous, active-high
//  in_address     in   `ADDRESS_WIDTH  word from last pipeline stage
//  in_id          in   `ID_WIDTH       tag from last pipeline stage
//  in_valid       in   1               word valid
//  out_stall      out  1               to pipeline: hold current word
//  out_address    out  `ADDRESS_WIDTH  head-of-buffer address
//  out_id         out  `ID_WIDTH       head-of-buffer id
//  out_valid      out  1               head entry valid
//  in_stall       in   1               from consumer: do not pop
//  accept_count   out  CNT_WIDTH       words accepted since reset, saturating
//  stall_cycles   out  CNT_WIDTH       cycles with out_stall=1 && in_valid=1, saturating
//  max_occupancy  out  $clog2(DEPTH)+1 high-water mark of entries held
// BEHAVIOUR
//  - Reset (sync, high): count=0, rd/wr ptrs=0, out_valid=0, out_stall=0, all counters/high-water=0;
//    out_address/out_id=0. Reset mid-transfer discards all held entries; no word is emitted afterwards.
//  - push = in_valid && !out_stall; pop = out_valid && !in_stall.
//  - out_stall = (count == DEPTH), driven from registered count only. Push when full is refused even
//    if a pop happens the same cycle (one-bubble cost accepted for timing isolation).
//  - out_valid = (count != 0); out_address/out_id = storage[rd_ptr]. While in_stall=1 and out_valid=1,
//    out_address/out_id/out_valid hold stable.
//  - Latency: word pushed in cycle N into empty buffer appears with out_valid=1 in cycle N+1.
//    No same-cycle bypass.
//  - Simultaneous push & pop (count not full, not empty): count unchanged, both ptrs advance.
//  - Pointers are log2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0; count is log2(DEPTH)+1 bits.
//  - Ordering: strict FIFO; id is passed through untouched, never reordered or dropped.
//  - accept_count += 1 per push; stall_cycles += 1 per cycle in_valid && out_stall; both stick at all-ones.
//  - max_occupancy updated to next-cycle count whenever it exceeds the stored value.
//  - in_valid=0 with in_stall=1 and empty buffer: no state change apart from nothing; counters idle.
// STRUCTURE
//  - defines.vh gains `SINK_DEPTH (4) and `SINK_CNT_WIDTH (16) as defaults for the two parameters.
//  - One sub-module: sync_fifo (storage array, ptrs, count, full/empty flags; data width parameter
//    = `ADDRESS_WIDTH+`ID_WIDTH). Top level adds stall/valid mapping and statistics counters.
//  - No other hierarchy; pipeline top instantiates this block on address[`PIPELINE_DEPTH] outputs.
// TESTING
//  1. Reset then single word addr=0x05,id=1, in_stall=0 -> out_valid=1 next cycle with 0x05/1,
//     gone after one cycle; accept_count=1, max_occupancy=1.
//  2. in_stall=1, push 4 words ids 0..3 -> out_stall=1 after 4th push; 5th word held at input,
//     stall_cycles increments each held cycle; max_occupancy=4.
//  3. From full, in_stall=0 and in_valid=1 for 8 cycles -> outputs ids 0,1,2,3 then 4.. in order,
//     no duplicates/drops; exactly one refused-push cycle at full.
//  4. Continuous push/pop at half occupancy for 3*DEPTH cycles -> count constant, pointers wrap,
//     data order preserved end to end.
//  5. Assert reset with 3 entries held -> next cycle out_valid=0, out_stall=0, counters=0; prior
//     words never appear.
//  6. Force accept_count near 16'hFFFE, push 3 words -> reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/pipeline_sink_buffer_pkg.sv
// Shared widths, defaults and the buffered word layout for the pipeline sink buffer.
package pipeline_sink_buffer_pkg;

  localparam int ADDRESS_WIDTH  = 8;
  localparam int ID_WIDTH       = 4;
  localparam int SINK_DEPTH     = 4;
  localparam int SINK_CNT_WIDTH = 16;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] address;
    logic [ID_WIDTH-1:0]      id;
  } sink_word_t;

  localparam int SINK_WORD_WIDTH = $bits(sink_word_t);

endpackage

// File: rtl/pipeline_sink_buffer_if.sv
// Handshake bundle between the last pipeline stage, the sink buffer and the final consumer.
interface pipeline_sink_buffer_if;
  import pipeline_sink_buffer_pkg::*;

  logic [ADDRESS_WIDTH-1:0] in_address;
  logic [ID_WIDTH-1:0]      in_id;
  logic                     in_valid;
  logic                     out_stall;
  logic [ADDRESS_WIDTH-1:0] out_address;
  logic [ID_WIDTH-1:0]      out_id;
  logic                     out_valid;
  logic                     in_stall;

  // Master is the environment (pipeline plus consumer); slave is the buffer itself.
  modport master (
    output in_address, in_id, in_valid, in_stall,
    input  out_stall, out_address, out_id, out_valid
  );

  modport slave (
    input  in_address, in_id, in_valid, in_stall,
    output out_stall, out_address, out_id, out_valid
  );

endinterface

// File: rtl/pipeline_sink_buffer_sync_fifo.sv
// Synchronous FIFO with registered count; also exposes the count the next edge will load.
module pipeline_sink_buffer_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_countNext
);

  logic [WIDTH-1:0] r_storage [DEPTH];
  logic [PW-1:0]    r_rdPtr;
  logic [PW-1:0]    r_wrPtr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Full and empty come only from the registered count, so a push at full is refused regardless of pop.
  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign w_push      = i_push && !o_full;
  assign w_pop       = i_pop && !o_empty;
  assign o_countNext = r_count + CW'(w_push) - CW'(w_pop);
  assign o_data      = r_storage[r_rdPtr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_storage[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_storage[r_wrPtr] <= i_data;
        r_wrPtr            <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      r_count <= o_countNext;
    end
  end

endmodule

// File: rtl/pipeline_sink_buffer.sv
// Elastic buffer after the address pipeline: FIFO, stall/valid mapping and saturating statistics.
module pipeline_sink_buffer
  import pipeline_sink_buffer_pkg::*;
#(
  parameter int DEPTH     = SINK_DEPTH,
  parameter int CNT_WIDTH = SINK_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  pipeline_sink_buffer_if.slave    bus,
  output logic [CNT_WIDTH-1:0]     accept_count,
  output logic [CNT_WIDTH-1:0]     stall_cycles,
  output logic [$clog2(DEPTH):0]   max_occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;

  sink_word_t             w_inWord;
  sink_word_t             w_headWord;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [CW-1:0]          w_countNext;
  logic [CNT_WIDTH-1:0]   r_acceptCount;
  logic [CNT_WIDTH-1:0]   r_stallCycles;
  logic [CW-1:0]          r_maxOccupancy;

  assign w_inWord = '{address: bus.in_address, id: bus.in_id};
  assign w_push   = bus.in_valid && !w_full;
  assign w_pop    = !w_empty && !bus.in_stall;

  pipeline_sink_buffer_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SINK_WORD_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_data      (w_inWord),
    .o_data      (w_headWord),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_countNext (w_countNext)
  );

  assign bus.out_stall   = w_full;
  assign bus.out_valid   = !w_empty;
  assign bus.out_address = w_headWord.address;
  assign bus.out_id      = w_headWord.id;

  // Statistics stick at all-ones; the high-water mark tracks the count loaded at this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acceptCount  <= '0;
      r_stallCycles  <= '0;
      r_maxOccupancy <= '0;
    end else begin
      if (w_push && (r_acceptCount != '1)) begin
        r_acceptCount <= r_acceptCount + CNT_WIDTH'(1);
      end
      if (bus.in_valid && w_full && (r_stallCycles != '1)) begin
        r_stallCycles <= r_stallCycles + CNT_WIDTH'(1);
      end
      if (w_countNext > r_maxOccupancy) begin
        r_maxOccupancy <= w_countNext;
      end
    end
  end

  assign accept_count  = r_acceptCount;
  assign stall_cycles  = r_stallCycles;
  assign max_occupancy = r_maxOccupancy;

endmodule

// File: tb/tb_pipeline_sink_buffer.sv
// Scoreboard bench: a queue model of the buffer predicts words, flags and statistics every cycle.
module tb_pipeline_sink_buffer;
  import pipeline_sink_buffer_pkg::*;

  localparam int DEPTH   = SINK_DEPTH;
  localparam int CNT_MAX = (1 << SINK_CNT_WIDTH) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [SINK_CNT_WIDTH-1:0] acceptCount, stallCycles;
  logic [$clog2(DEPTH):0]    maxOccupancy;
  logic [1:0]                satAccept, satStall;
  logic [$clog2(DEPTH):0]    satMaxOcc;

  pipeline_sink_buffer_if bus ();
  pipeline_sink_buffer_if satBus ();

  always #5 clk = ~clk;

  pipeline_sink_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .accept_count  (acceptCount),
    .stall_cycles  (stallCycles),
    .max_occupancy (maxOccupancy)
  );

  // Narrow counters let saturation be reached in a handful of cycles.
  pipeline_sink_buffer #(.DEPTH(DEPTH), .CNT_WIDTH(2)) dutSat (
    .clk           (clk),
    .reset         (reset),
    .bus           (satBus.slave),
    .accept_count  (satAccept),
    .stall_cycles  (satStall),
    .max_occupancy (satMaxOcc)
  );

  sink_word_t  expectQ[$];
  int          occ;
  int          expAccept, expStall, expMaxOcc;
  bit          pendPush, pendPop, pendStall, pendReset;
  bit          monOn, justReset;
  logic [ADDRESS_WIDTH-1:0] curAddr;
  logic [ID_WIDTH-1:0]      curId;
  int          checks, passes;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, actual, actual, expected, expected, $time);
  endtask

  // One clock of stimulus: fold the last cycle's decisions into the model, then drive and predict.
  task automatic applyStimulus(input bit v, input bit s, input bit r);
    @(posedge clk);
    #1;
    if (pendReset) begin
      occ = 0; expAccept = 0; expStall = 0; expMaxOcc = 0;
      expectQ.delete();
      justReset = 1'b1;
      monOn     = 1'b1;
    end else begin
      if (pendPush) begin
        curAddr = ADDRESS_WIDTH'($urandom);
        curId   = curId + 1'b1;
      end
      occ = occ + int'(pendPush) - int'(pendPop);
      if (pendPush && expAccept < CNT_MAX) expAccept++;
      if (pendStall && expStall < CNT_MAX) expStall++;
      if (occ > expMaxOcc) expMaxOcc = occ;
      justReset = 1'b0;
    end
    reset          = r;
    bus.in_valid   = v;
    bus.in_stall   = s;
    bus.in_address = curAddr;
    bus.in_id      = curId;
    pendReset = r;
    pendPush  = !r && v && (occ < DEPTH);
    pendPop   = !r && (occ > 0) && !s;
    pendStall = !r && v && (occ == DEPTH);
    if (pendPush) expectQ.push_back('{address: curAddr, id: curId});
  endtask

  // Monitor: compares whatever the DUT presents against the model, away from the active edge.
  always @(negedge clk) begin
    if (monOn) begin
      checkOutput("out_valid", int'(bus.out_valid), int'(occ != 0));
      checkOutput("out_stall", int'(bus.out_stall), int'(occ == DEPTH));
      checkOutput("accept_count", int'(acceptCount), expAccept);
      checkOutput("stall_cycles", int'(stallCycles), expStall);
      checkOutput("max_occupancy", int'(maxOccupancy), expMaxOcc);
      if (justReset) begin
        checkOutput("reset_address", int'(bus.out_address), 0);
        checkOutput("reset_id", int'(bus.out_id), 0);
      end
      if (bus.out_valid) begin
        if (expectQ.size() == 0) begin
          checkOutput("unexpected_word", 1, 0);
        end else begin
          checkOutput("out_address", int'(bus.out_address), int'(expectQ[0].address));
          checkOutput("out_id", int'(bus.out_id), int'(expectQ[0].id));
          if (!bus.in_stall) void'(expectQ.pop_front());
        end
      end
    end
  end

  initial begin
    checks = 0; passes = 0; occ = 0;
    expAccept = 0; expStall = 0; expMaxOcc = 0;
    pendPush = 0; pendPop = 0; pendStall = 0; pendReset = 0;
    monOn = 0; justReset = 0;
    curAddr = '0; curId = '0;
    reset = 1'b1;
    bus.in_valid = 0; bus.in_stall = 0; bus.in_address = '0; bus.in_id = '0;
    satBus.in_valid = 0; satBus.in_stall = 0; satBus.in_address = '0; satBus.in_id = '0;

    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);

    // Single word through an empty buffer.
    curAddr = 8'h05; curId = 4'd1;
    applyStimulus(1, 0, 0);
    repeat (3) applyStimulus(0, 0, 0);

    // Fill while the consumer stalls, then hold a fifth word at the input.
    curId = 4'd0;
    repeat (4) applyStimulus(1, 1, 0);
    repeat (3) applyStimulus(1, 1, 0);

    // Drain from full with the pipeline still pushing.
    repeat (8) applyStimulus(1, 0, 0);
    repeat (6) applyStimulus(0, 0, 0);

    // Half occupancy, then continuous push/pop long enough to wrap pointers.
    repeat (DEPTH / 2) applyStimulus(1, 1, 0);
    repeat (3 * DEPTH) applyStimulus(1, 0, 0);
    repeat (6) applyStimulus(0, 0, 0);

    // Reset with three entries held.
    repeat (3) applyStimulus(1, 1, 0);
    applyStimulus(0, 1, 1);
    repeat (4) applyStimulus(0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 0);
    end
    repeat (8) applyStimulus(0, 0, 0);

    // Saturation on the narrow instance: 9 pushes and 7 stalled cycles into 2-bit counters.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0);
      satBus.in_valid = 1; satBus.in_stall = 0; satBus.in_address = ADDRESS_WIDTH'(i);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0);
      satBus.in_valid = 1; satBus.in_stall = 1;
    end
    applyStimulus(0, 0, 0);
    satBus.in_valid = 0;
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("sat_accept_count", int'(satAccept), 3);
    checkOutput("sat_stall_cycles", int'(satStall), 3);
    checkOutput("sat_max_occupancy", int'(satMaxOcc), DEPTH);
    checkOutput("sat_out_stall", int'(satBus.out_stall), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
